// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU arbiter: FUNCT codes, arbiter states,
// datapath widths and the legal-function check.
package alu_pkg;

   localparam int DATA_W  = 8;
   localparam int FUNCT_W = 4;

   typedef enum logic [FUNCT_W-1:0] {
      F_XOR = 4'd0,
      F_LW  = 4'd1,
      F_SW  = 4'd2,
      F_MOV = 4'd3,
      F_PUT = 4'd4,
      F_ADD = 4'd5,
      F_SUB = 4'd6,
      F_SL  = 4'd7,
      F_SR  = 4'd8,
      F_INC = 4'd9,
      F_DEC = 4'd10,
      F_AND = 4'd11
   } funct_e;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOCK0 = 2'd1,
      LOCK1 = 2'd2
   } arb_state_e;

   // Codes past AND are unassigned in the ALU.
   function automatic logic is_legal_funct(input logic [FUNCT_W-1:0] funct);
      return funct <= FUNCT_W'(F_AND);
   endfunction

endpackage

// File: rtl/alu_rsp_slot.sv
// Single-entry response register: load wins over drain, drain clears only valid
// so data/err hold their last value.
module alu_rsp_slot
   import alu_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic              drain,
   input  logic [DATA_W-1:0] load_data,
   input  logic              load_err,
   output logic              valid,
   output logic [DATA_W-1:0] data,
   output logic              err
);

   logic              valid_q, valid_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic              err_q, err_d;

   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      err_d   = err_q;
      if (load) begin
         valid_d = 1'b1;
         data_d  = load_data;
         err_d   = load_err;
      end else if (drain) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         data_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
         err_q   <= err_d;
      end
   end

   assign valid = valid_q;
   assign data  = data_q;
   assign err   = err_q;

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter with bounded lock sharing one combinational ALU between two requesters.
// Define ALU_ARB_ILLEGAL_CHK_EN to flag FUNCT codes above AND and squash them to 0000.
module alu_arbiter
   import alu_pkg::*;
#(
   parameter int LOCK_MAX = 16
) (
   input  logic                        CLK,
   input  logic                        RESET_N,
   input  logic [1:0]                  REQ_VALID,
   output logic [1:0]                  REQ_READY,
   input  logic [1:0]                  REQ_LOCK,
   input  logic [1:0][FUNCT_W-1:0]     REQ_FUNCT,
   input  logic [1:0][DATA_W-1:0]      REQ_A,
   input  logic [1:0][DATA_W-1:0]      REQ_B,
   output logic [1:0]                  RSP_VALID,
   input  logic [1:0]                  RSP_READY,
   output logic [1:0][DATA_W-1:0]      RSP_DATA,
   output logic [1:0]                  RSP_ERR,
   output logic                        ALU_OP,
   output logic [FUNCT_W-1:0]          ALU_FUNCT,
   output logic [DATA_W-1:0]           ALU_A,
   output logic [DATA_W-1:0]           ALU_B,
   input  logic [DATA_W-1:0]           ALU_OUT
);

   localparam logic [7:0] LOCK_LAST = 8'(LOCK_MAX - 1);

   arb_state_e        state_q, state_d;
   logic              rr_q, rr_d;
   logic [7:0]        lock_cnt_q, lock_cnt_d;
   logic [1:0]        slot_free, elig, grant;
   logic              gsel, illegal;
   logic [DATA_W-1:0] rsp_load_data;

   assign slot_free = ~RSP_VALID | RSP_READY;
   assign elig      = REQ_VALID & slot_free;

   always_comb begin
      grant = 2'b00;
      case (state_q)
         IDLE:    grant = (elig == 2'b11) ? (rr_q ? 2'b10 : 2'b01) : elig;
         LOCK0:   grant = {1'b0, elig[0]};
         LOCK1:   grant = {elig[1], 1'b0};
         default: grant = 2'b00;
      endcase
   end

   assign REQ_READY = grant;
   assign gsel      = grant[1];
   assign ALU_OP    = 1'b0;

`ifdef ALU_ARB_ILLEGAL_CHK_EN
   assign illegal = (|grant) && !is_legal_funct(REQ_FUNCT[gsel]);
`else
   assign illegal = 1'b0;
`endif

   always_comb begin
      ALU_FUNCT = '0;
      ALU_A     = '0;
      ALU_B     = '0;
      if (|grant) begin
         ALU_FUNCT = illegal ? '0 : REQ_FUNCT[gsel];
         ALU_A     = REQ_A[gsel];
         ALU_B     = REQ_B[gsel];
      end
   end

   assign rsp_load_data = illegal ? '0 : ALU_OUT;

   always_comb begin
      state_d    = state_q;
      rr_d       = rr_q;
      lock_cnt_d = lock_cnt_q;
      if (|grant) rr_d = ~gsel;
      case (state_q)
         IDLE: begin
            if ((|grant) && REQ_LOCK[gsel]) begin
               state_d    = gsel ? LOCK1 : LOCK0;
               lock_cnt_d = '0;
            end
         end
         LOCK0, LOCK1: begin
            // The lock budget runs on wall-clock cycles, not on accepted ops.
            lock_cnt_d = lock_cnt_q + 8'd1;
            if (lock_cnt_q == LOCK_LAST) begin
               state_d    = IDLE;
               rr_d       = (state_q == LOCK0);
               lock_cnt_d = '0;
            end else if ((|grant) && !REQ_LOCK[gsel]) begin
               state_d    = IDLE;
               lock_cnt_d = '0;
            end
         end
         default: begin
            state_d    = IDLE;
            lock_cnt_d = '0;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!RESET_N) begin
         state_q    <= IDLE;
         rr_q       <= 1'b0;
         lock_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         rr_q       <= rr_d;
         lock_cnt_q <= lock_cnt_d;
      end
   end

   for (genvar k = 0; k < 2; k++) begin : g_slot
      alu_rsp_slot u_slot (
         .clk       (CLK),
         .rst_n     (RESET_N),
         .load      (grant[k]),
         .drain     (RSP_READY[k]),
         .load_data (rsp_load_data),
         .load_err  (illegal),
         .valid     (RSP_VALID[k]),
         .data      (RSP_DATA[k]),
         .err       (RSP_ERR[k])
      );
   end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios then random traffic, checked by a
// cycle-level reference model feeding per-requester response scoreboards.
module tb_alu_arbiter;

   localparam int LOCK_MAX = 4;

   typedef struct {
      logic [7:0] d;
      logic       e;
   } rsp_t;

   logic            CLK = 1'b0;
   logic            RESET_N;
   logic [1:0]      REQ_VALID, REQ_READY, REQ_LOCK;
   logic [1:0][3:0] REQ_FUNCT;
   logic [1:0][7:0] REQ_A, REQ_B;
   logic [1:0]      RSP_VALID, RSP_READY, RSP_ERR;
   logic [1:0][7:0] RSP_DATA;
   logic            ALU_OP;
   logic [3:0]      ALU_FUNCT;
   logic [7:0]      ALU_A, ALU_B, ALU_OUT;

   int n_total = 0;
   int n_pass  = 0;

   rsp_t sbq0[$];
   rsp_t sbq1[$];

   alu_arbiter #(.LOCK_MAX(LOCK_MAX)) dut (
      .CLK(CLK), .RESET_N(RESET_N),
      .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_LOCK(REQ_LOCK),
      .REQ_FUNCT(REQ_FUNCT), .REQ_A(REQ_A), .REQ_B(REQ_B),
      .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_DATA(RSP_DATA), .RSP_ERR(RSP_ERR),
      .ALU_OP(ALU_OP), .ALU_FUNCT(ALU_FUNCT), .ALU_A(ALU_A), .ALU_B(ALU_B), .ALU_OUT(ALU_OUT)
   );

   always #5 CLK = ~CLK;

   // Behavioural ALU standing in for the real one.
   function automatic logic [7:0] alu_ref(input logic [3:0] f, input logic [7:0] a, input logic [7:0] b);
      case (f)
         4'd0:    return a ^ b;
         4'd1:    return a + b;
         4'd2:    return a + b;
         4'd3:    return b;
         4'd4:    return a;
         4'd5:    return a + b;
         4'd6:    return a - b;
         4'd7:    return a << b[2:0];
         4'd8:    return a >> b[2:0];
         4'd9:    return b + 8'd1;
         4'd10:   return b - 8'd1;
         4'd11:   return a & b;
         default: return a ~^ b;
      endcase
   endfunction

   always_comb ALU_OUT = alu_ref(ALU_FUNCT, ALU_A, ALU_B);

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   // Reference model: owner -1 means no lock held.
   int         m_owner, m_held, g;
   logic       m_rr, ill;
   logic [1:0] m_pend, free, elig, eg;
   logic [3:0] f, ef;
   logic [7:0] ea, eb;
   rsp_t       r;

   always @(negedge CLK) begin
      if (!RESET_N) begin
         m_owner = -1; m_held = 0; m_rr = 1'b0; m_pend = 2'b00;
         sbq0.delete(); sbq1.delete();
      end else begin
         free = ~m_pend | RSP_READY;
         elig = REQ_VALID & free;
         g = -1;
         if (m_owner < 0) begin
            if (elig == 2'b11) g = int'(m_rr);
            else if (elig[0]) g = 0;
            else if (elig[1]) g = 1;
         end else if (elig[m_owner]) g = m_owner;
         eg = 2'b00;
         if (g >= 0) eg[g] = 1'b1;
         chk("req_ready", 32'(REQ_READY), 32'(eg));
         chk("rsp_valid", 32'(RSP_VALID), 32'(m_pend));
         f = 4'd0; ill = 1'b0; ef = 4'd0; ea = 8'd0; eb = 8'd0;
         if (g >= 0) begin
            f = REQ_FUNCT[g];
`ifdef ALU_ARB_ILLEGAL_CHK_EN
            ill = (f > 4'd11);
`endif
            ef = ill ? 4'd0 : f;
            ea = REQ_A[g];
            eb = REQ_B[g];
         end
         chk("alu_drive", {15'd0, ALU_OP, ALU_FUNCT, ALU_A, ALU_B}, {16'd0, ef, ea, eb});
         m_pend = m_pend & ~RSP_READY;
         if (g >= 0) begin
            r.d = ill ? 8'd0 : alu_ref(f, ea, eb);
            r.e = ill;
            if (g == 0) sbq0.push_back(r); else sbq1.push_back(r);
            m_pend[g] = 1'b1;
            m_rr = (g == 0);
         end
         if (m_owner < 0) begin
            if (g >= 0 && REQ_LOCK[g]) begin m_owner = g; m_held = 0; end
         end else begin
            m_held++;
            if (m_held == LOCK_MAX) begin m_rr = (m_owner == 0); m_owner = -1; end
            else if (g >= 0 && !REQ_LOCK[g]) m_owner = -1;
         end
      end
   end

   // Monitor: compares what each slot presents against its scoreboard queue.
   logic [1:0][7:0] last_d;
   logic [1:0]      last_e;
   rsp_t            mr;

   always @(negedge CLK) begin
      if (!RESET_N) begin
         last_d = '0; last_e = '0;
      end else begin
         for (int k = 0; k < 2; k++) begin
            if (RSP_VALID[k]) begin
               if ((k == 0 ? sbq0.size() : sbq1.size()) == 0) begin
                  chk($sformatf("rsp_unexpected%0d", k), 32'd1, 32'd0);
               end else begin
                  mr = (k == 0) ? sbq0[0] : sbq1[0];
                  chk($sformatf("rsp_data%0d", k), 32'(RSP_DATA[k]), 32'(mr.d));
                  chk($sformatf("rsp_err%0d", k), 32'(RSP_ERR[k]), 32'(mr.e));
                  if (RSP_READY[k]) begin
                     if (k == 0) void'(sbq0.pop_front()); else void'(sbq1.pop_front());
                     last_d[k] = mr.d;
                     last_e[k] = mr.e;
                  end
               end
            end else begin
               chk($sformatf("rsp_hold_data%0d", k), 32'(RSP_DATA[k]), 32'(last_d[k]));
               chk($sformatf("rsp_hold_err%0d", k), 32'(RSP_ERR[k]), 32'(last_e[k]));
            end
         end
      end
   end

   task automatic drive(input logic [1:0] v, input logic [1:0] l,
                        input logic [3:0] f0, input logic [7:0] a0, input logic [7:0] b0,
                        input logic [3:0] f1, input logic [7:0] a1, input logic [7:0] b1,
                        input logic [1:0] rr);
      REQ_VALID = v; REQ_LOCK = l;
      REQ_FUNCT[0] = f0; REQ_A[0] = a0; REQ_B[0] = b0;
      REQ_FUNCT[1] = f1; REQ_A[1] = a1; REQ_B[1] = b1;
      RSP_READY = rr;
      @(posedge CLK); #1;
   endtask

   initial begin
      RESET_N = 1'b0;
      drive(2'b00, 2'b00, 4'd0, 8'd0, 8'd0, 4'd0, 8'd0, 8'd0, 2'b00);
      drive(2'b00, 2'b00, 4'd0, 8'd0, 8'd0, 4'd0, 8'd0, 8'd0, 2'b00);
      RESET_N = 1'b1;
      drive(2'b00, 2'b00, 4'd0, 8'd0, 8'd0, 4'd0, 8'd0, 8'd0, 2'b11);
      // single op
      drive(2'b01, 2'b00, 4'd5, 8'h05, 8'h03, 4'd0, 8'd0, 8'd0, 2'b11);
      drive(2'b00, 2'b00, 4'd0, 8'd0, 8'd0, 4'd0, 8'd0, 8'd0, 2'b11);
      // contention
      for (int i = 0; i < 5; i++)
         drive(2'b11, 2'b00, 4'd6, 8'h10, 8'h01, 4'd0, 8'hF0, 8'h0F, 2'b11);
      drive(2'b00, 2'b00, 4'd0, 8'd0, 8'd0, 4'd0, 8'd0, 8'd0, 2'b11);
      // backpressure, then same-cycle drain+accept, then drain only
      drive(2'b01, 2'b00, 4'd9, 8'h00, 8'hFF, 4'd0, 8'd0, 8'd0, 2'b00);
      drive(2'b01, 2'b00, 4'd5, 8'h21, 8'h12, 4'd0, 8'd0, 8'd0, 2'b00);
      drive(2'b01, 2'b00, 4'd5, 8'h21, 8'h12, 4'd0, 8'd0, 8'd0, 2'b00);
      drive(2'b01, 2'b00, 4'd5, 8'h21, 8'h12, 4'd0, 8'd0, 8'd0, 2'b01);
      drive(2'b00, 2'b00, 4'd0, 8'd0, 8'd0, 4'd0, 8'd0, 8'd0, 2'b01);
      drive(2'b00, 2'b00, 4'd0, 8'd0, 8'd0, 4'd0, 8'd0, 8'd0, 2'b01);
      // lock by req1 with req0 waiting: timeout after LOCK_MAX cycles
      for (int i = 0; i < 8; i++)
         drive(2'b11, 2'b10, 4'd5, 8'd1, 8'd2, 4'd11, 8'h3C, 8'h0F, 2'b11);
      // owner drops valid mid-lock: lock is still held until timeout
      drive(2'b10, 2'b10, 4'd0, 8'd0, 8'd0, 4'd3, 8'd0, 8'h44, 2'b11);
      for (int i = 0; i < 5; i++)
         drive(2'b01, 2'b00, 4'd4, 8'h5A, 8'd0, 4'd0, 8'd0, 8'd0, 2'b11);
      // reset mid-lock with both slots full
      drive(2'b01, 2'b00, 4'd5, 8'd1, 8'd2, 4'd0, 8'd0, 8'd0, 2'b00);
      drive(2'b10, 2'b10, 4'd0, 8'd0, 8'd0, 4'd6, 8'd9, 8'd4, 2'b00);
      RESET_N = 1'b0;
      drive(2'b11, 2'b00, 4'd0, 8'd0, 8'd0, 4'd0, 8'd0, 8'd0, 2'b00);
      RESET_N = 1'b1;
      drive(2'b11, 2'b00, 4'd7, 8'h03, 8'd2, 4'd8, 8'h80, 8'd3, 2'b11);
      drive(2'b11, 2'b00, 4'd7, 8'h03, 8'd2, 4'd8, 8'h80, 8'd3, 2'b11);
      // illegal code
      drive(2'b01, 2'b00, 4'hF, 8'h12, 8'h34, 4'd0, 8'd0, 8'd0, 2'b11);
      drive(2'b00, 2'b00, 4'd0, 8'd0, 8'd0, 4'd0, 8'd0, 8'd0, 2'b11);
      // random traffic with occasional resets
      for (int i = 0; i < 600; i++) begin
         RESET_N = ($urandom_range(0, 149) != 0);
         drive(2'($urandom), ($urandom_range(0, 2) == 0) ? 2'($urandom) : 2'b00,
               4'($urandom), 8'($urandom), 8'($urandom),
               4'($urandom), 8'($urandom), 8'($urandom),
               {($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0)});
      end
      RESET_N = 1'b1;
      for (int i = 0; i < 3; i++)
         drive(2'b00, 2'b00, 4'd0, 8'd0, 8'd0, 4'd0, 8'd0, 8'd0, 2'b11);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
